// File: rtl/mem_pkg.sv
// Shared types for the unified-memory port arbiter: word width, FSM state
// encoding and requester identity.
package mem_pkg;

  localparam int WORD_SIZE = 16;
  // Wide enough for the largest legal access window (LATENCY up to 15).
  localparam int CNT_W     = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  function automatic owner_e other_port(input owner_e o);
    return (o == OWN_I) ? OWN_D : OWN_I;
  endfunction

endpackage

// File: rtl/mem_rr_arbiter.sv
// Two-way round-robin grant between the fetch (I) and load/store (D) requesters.
// The port that was just served can be masked so the other side gets a back-to-back slot.
module mem_rr_arbiter
  import mem_pkg::*;
(
  input  logic   clk,
  input  logic   reset_n,
  input  logic   enable_i,
  input  logic   req_fetch_i,
  input  logic   req_ls_i,
  input  logic   mask_en_i,
  input  owner_e mask_owner_i,
  output logic   grant_valid_o,
  output owner_e grant_owner_o
);

  owner_e last_q;
  owner_e last_d;
  logic   elig_fetch;
  logic   elig_ls;

  // NOTE: every output of a combinational block is assigned on every path,
  // otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    elig_fetch = enable_i & req_fetch_i & ~(mask_en_i & (mask_owner_i == OWN_I));
    elig_ls    = enable_i & req_ls_i    & ~(mask_en_i & (mask_owner_i == OWN_D));

    grant_valid_o = elig_fetch | elig_ls;
    if (elig_fetch && elig_ls) begin
      grant_owner_o = other_port(last_q);
    end else if (elig_ls) begin
      grant_owner_o = OWN_D;
    end else begin
      grant_owner_o = OWN_I;
    end

    last_d = grant_valid_o ? grant_owner_o : last_q;
  end

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_q <= OWN_D;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises fetch and load/store accesses onto the single memory port, holds the
// strobes for LATENCY cycles and returns data with a one-cycle ready pulse.
module mem_port_arbiter #(
  parameter int WORD_SIZE = mem_pkg::WORD_SIZE,
  parameter int LATENCY   = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_req,
  input  logic [WORD_SIZE-1:0] i_addr,
  output logic                 i_ready,
  output logic [WORD_SIZE-1:0] i_rdata,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [WORD_SIZE-1:0] d_addr,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic                 d_ready,
  output logic [WORD_SIZE-1:0] d_rdata,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata
);

  import mem_pkg::*;

  localparam logic [CNT_W-1:0] COUNT_START = CNT_W'(LATENCY - 1);

  state_e               state_q,   state_d;
  logic [CNT_W-1:0]     count_q,   count_d;
  owner_e               owner_q,   owner_d;
  logic                 we_q,      we_d;
  logic [WORD_SIZE-1:0] addr_q,    addr_d;
  logic [WORD_SIZE-1:0] wdata_q,   wdata_d;
  logic [WORD_SIZE-1:0] i_rdata_q, i_rdata_d;
  logic [WORD_SIZE-1:0] d_rdata_q, d_rdata_d;

  logic   arb_enable;
  logic   grant_valid;
  owner_e grant_owner;
  logic   in_access;

  mem_rr_arbiter u_arbiter (
    .clk           (clk),
    .reset_n       (reset_n),
    .enable_i      (arb_enable),
    .req_fetch_i   (i_req),
    .req_ls_i      (d_req),
    .mask_en_i     (state_q == ST_RESP),
    .mask_owner_i  (owner_q),
    .grant_valid_o (grant_valid),
    .grant_owner_o (grant_owner)
  );

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    owner_d   = owner_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    arb_enable = 1'b0;

    case (state_q)
      ST_IDLE, ST_RESP: begin
        arb_enable = 1'b1;
        if (grant_valid) begin
          state_d = ST_ACCESS;
          count_d = COUNT_START;
          owner_d = grant_owner;
          // The fetch port is read-only, so its accesses never carry write data.
          if (grant_owner == OWN_D) begin
            we_d    = d_we;
            addr_d  = d_addr;
            wdata_d = d_wdata;
          end else begin
            we_d    = 1'b0;
            addr_d  = i_addr;
            wdata_d = '0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_ACCESS: begin
        if (count_q == '0) begin
          state_d = ST_RESP;
          if (!we_q) begin
            if (owner_q == OWN_I) begin
              i_rdata_d = mem_rdata;
            end else begin
              d_rdata_d = mem_rdata;
            end
          end
        end else begin
          count_d = count_q - 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: the rdata holding registers are reset too, so a read before the first
  // completion returns a defined zero rather than X.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      owner_q   <= OWN_I;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      owner_q   <= owner_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  // Strobes decode straight from the state register, so reset drops them at once.
  assign in_access = (state_q == ST_ACCESS);
  assign mem_read  = in_access & ~we_q;
  assign mem_write = in_access &  we_q;
  assign mem_addr  = in_access ? addr_q : '0;
  // Keep the shared bidirectional bus quiet except during a write.
  assign mem_wdata = mem_write ? wdata_q : '0;

  assign i_ready = (state_q == ST_RESP) && (owner_q == OWN_I);
  assign d_ready = (state_q == ST_RESP) && (owner_q == OWN_D);
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: drivers queue expected responses from a
// reference memory, a negedge monitor checks every ready pulse and strobe window.
module tb_mem_port_arbiter;
  import mem_pkg::*;

  localparam int LAT = 2;
  localparam int W   = 16;

  logic         clk;
  logic         reset_n;
  logic         i_req;
  logic [W-1:0] i_addr;
  logic         i_ready;
  logic [W-1:0] i_rdata;
  logic         d_req;
  logic         d_we;
  logic [W-1:0] d_addr;
  logic [W-1:0] d_wdata;
  logic         d_ready;
  logic [W-1:0] d_rdata;
  logic         mem_read;
  logic         mem_write;
  logic [W-1:0] mem_addr;
  logic [W-1:0] mem_wdata;
  logic [W-1:0] mem_rdata;

  mem_port_arbiter #(.WORD_SIZE(W), .LATENCY(LAT)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_ready   (i_ready),
    .i_rdata   (i_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_ready   (d_ready),
    .d_rdata   (d_rdata),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] init_word(input int i);
    if (i == 'h23) return 16'h6000;
    return 16'(i * 16'h9E37) ^ 16'h5A5A;
  endfunction

  // 256x16 memory device: combinational read, write on the rising edge.
  logic [15:0] mem [256];
  assign mem_rdata = mem[mem_addr[7:0]];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = init_word(i);
    forever begin
      @(posedge clk);
      if (mem_write) mem[mem_addr[7:0]] = mem_wdata;
    end
  end

  // Reference model: expected memory contents as seen by requests at issue time.
  logic [15:0] ref_mem [256];

  typedef struct {
    logic        we;
    logic [15:0] data;
  } exp_t;

  logic [15:0] exp_i[$];
  exp_t        exp_d[$];
  owner_e      done_log[$];

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every ready pulse, checks strobe windows.
  initial begin
    int          run_len;
    logic        prev_i;
    logic        prev_d;
    logic [15:0] last_load;
    exp_t        e;
    run_len = 0; prev_i = 0; prev_d = 0; last_load = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        run_len = 0; prev_i = 0; prev_d = 0; last_load = '0;
      end else begin
        if (i_ready) begin
          check("i_ready_width", {15'b0, prev_i}, 16'd0);
          if (exp_i.size() == 0) check("i_unexpected_ready", 16'd1, 16'd0);
          else check("i_rdata", i_rdata, exp_i.pop_front());
          done_log.push_back(OWN_I);
        end
        if (d_ready) begin
          check("d_ready_width", {15'b0, prev_d}, 16'd0);
          if (exp_d.size() == 0) check("d_unexpected_ready", 16'd1, 16'd0);
          else begin
            e = exp_d.pop_front();
            if (e.we) check("d_rdata_store_hold", d_rdata, last_load);
            else begin
              check("d_rdata", d_rdata, e.data);
              last_load = e.data;
            end
          end
          done_log.push_back(OWN_D);
        end
        if (mem_read) check("mem_wdata_quiet", mem_wdata, 16'd0);
        if (mem_read || mem_write) begin
          run_len++;
        end else if (run_len != 0) begin
          check("strobe_len", 16'(run_len), 16'(LAT));
          run_len = 0;
        end
        prev_i = i_ready;
        prev_d = d_ready;
      end
    end
  end

  task automatic i_access(input logic [15:0] a);
    int n;
    exp_i.push_back(ref_mem[a[7:0]]);
    i_req  = 1'b1;
    i_addr = a;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!i_ready && n < 200);
    check("i_handshake", {15'b0, i_ready}, 16'd1);
    i_req = 1'b0;
  endtask

  task automatic d_access(input logic we, input logic [15:0] a, input logic [15:0] wd);
    int   n;
    exp_t e;
    e.we = we;
    if (we) begin
      ref_mem[a[7:0]] = wd;
      e.data = wd;
    end else begin
      e.data = ref_mem[a[7:0]];
    end
    exp_d.push_back(e);
    d_req   = 1'b1;
    d_we    = we;
    d_addr  = a;
    d_wdata = wd;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!d_ready && n < 200);
    check("d_handshake", {15'b0, d_ready}, 16'd1);
    d_req = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    reset_n = 1'b0;
    i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;

    repeat (3) @(negedge clk);
    check("rst_mem_read",  {15'b0, mem_read},  16'd0);
    check("rst_mem_write", {15'b0, mem_write}, 16'd0);
    check("rst_ready",     {14'b0, i_ready, d_ready}, 16'd0);
    check("rst_i_rdata",   i_rdata, 16'd0);
    check("rst_d_rdata",   d_rdata, 16'd0);
    check("rst_mem_addr",  mem_addr, 16'd0);
    reset_n = 1'b1;

    // Simultaneous requests after reset: last_grant starts at D, so I wins,
    // and D is granted straight out of I's response cycle.
    @(negedge clk);
    exp_i.push_back(ref_mem[8'h05]);
    exp_d.push_back('{we: 1'b0, data: ref_mem[8'h90]});
    i_req = 1; i_addr = 16'h0005;
    d_req = 1; d_we = 0; d_addr = 16'h0090;
    for (int k = 1; k <= 2 * LAT + 2; k++) begin
      @(negedge clk);
      if (k == LAT + 1) begin
        check("both_i_first", {14'b0, i_ready, d_ready}, 16'b10);
        i_req = 0;
      end
      if (k == LAT + 2) check("both_no_gap", {15'b0, mem_read}, 16'd1);
      if (k == 2 * LAT + 2) begin
        check("both_d_second", {14'b0, i_ready, d_ready}, 16'b01);
        d_req = 0;
      end
    end

    // Single fetch: strobe cycles 1..LAT, ready in LAT+1.
    @(negedge clk);
    exp_i.push_back(ref_mem[8'h23]);
    i_req = 1; i_addr = 16'h0023;
    for (int k = 1; k <= LAT + 1; k++) begin
      @(negedge clk);
      if (k <= LAT) begin
        check("fetch_strobe", {14'b0, mem_read, i_ready}, 16'b10);
        check("fetch_addr", mem_addr, 16'h0023);
      end else begin
        check("fetch_ready", {14'b0, mem_read, i_ready}, 16'b01);
        check("fetch_data", i_rdata, 16'h6000);
        i_req = 0;
      end
    end

    // Store then load back; fetch data must be untouched. Upper address bits ignored.
    d_access(1'b1, 16'h0010, 16'hBEEF);
    d_access(1'b0, 16'h0010, 16'h0000);
    check("i_rdata_hold", i_rdata, 16'h6000);
    i_access(16'hAB23);

    // Continuous re-requests from both sides must strictly alternate.
    done_log.delete();
    fork
      for (int k = 0; k < 4; k++) i_access(16'(k * 3));
      for (int k = 0; k < 4; k++) d_access(1'(k % 2), 16'(16'h00A0 + k), 16'(16'h1234 + k));
    join
    check("alt_count", 16'(done_log.size()), 16'd8);
    for (int k = 1; k < done_log.size(); k++)
      check("alt_order", 16'(done_log[k] == done_log[k-1]), 16'd0);

    // Reset in the middle of an access aborts it without a ready pulse.
    @(negedge clk);
    i_req = 1; i_addr = 16'h0030;
    @(posedge clk);
    #1 check("abort_pre_strobe", {15'b0, mem_read}, 16'd1);
    #1 reset_n = 1'b0;
    #1 check("abort_strobe_drop", {14'b0, mem_read, mem_write}, 16'd0);
    i_req = 0;
    repeat (2) begin
      @(negedge clk);
      check("abort_no_ready", {14'b0, i_ready, d_ready}, 16'd0);
    end
    reset_n = 1'b1;
    i_access(16'h0031);

    // Randomised traffic: fetches in the low half, loads/stores in the high half.
    fork
      for (int k = 0; k < 30; k++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        i_access({8'($urandom), 1'b0, 7'($urandom)});
      end
      for (int k = 0; k < 30; k++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        d_access(1'($urandom), {8'($urandom), 1'b1, 7'($urandom)}, 16'($urandom));
      end
    join
    repeat (4) @(negedge clk);
    check("i_queue_drained", 16'(exp_i.size()), 16'd0);
    check("d_queue_drained", 16'(exp_d.size()), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
